// File: rtl/amm_cfg_master.sv
// amm_cfg_master
// Avalon-MM master that programs the key-pattern control register block.
// Sequence: disable matching (ctrl=0), write every pattern word, read each one
// back and compare, then write the control word carrying the requested enable.
// A readback mismatch or a read timeout ends the sequence with error_o set and
// leaves matching disabled.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start_i; bus idle
// WR_DIS  | writing 0 to the control register (address 0)
// WR_PAT  | writing shadow[idx] to address idx+1
// RD_REQ  | read request to address idx+1, held until accepted
// RD_WAIT | waiting for readdatavalid; timer bounds the wait
// WR_CTRL | writing {0..0, enable} to the control register
// DONE    | one-cycle done_o pulse, then back to IDLE

module amm_cfg_master #(
    parameter int REG_WIDTH  = 32,
    parameter int REG_DEPTH  = 4,
    parameter int RD_TIMEOUT = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                  clk_i,
    input  logic                                  srst_i,
    input  logic                                  start_i,
    input  logic [REG_DEPTH-2:0][REG_WIDTH-1:0]   pattern_i,
    input  logic                                  enable_i,
    output logic [ADDR_WIDTH-1:0]                 amm_address,
    output logic                                  amm_write,
    output logic [REG_WIDTH-1:0]                  amm_writedata,
    output logic                                  amm_read,
    input  logic                                  amm_waitrequest,
    input  logic [REG_WIDTH-1:0]                  amm_readdata,
    input  logic                                  amm_readdatavalid,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  error_o
);

    localparam int PAT_WIDTH = REG_DEPTH - 1;
    localparam int IDX_W     = (REG_DEPTH > 2) ? $clog2(REG_DEPTH) : 1;
    localparam int TMR_W     = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_DIS,
        WR_PAT,
        RD_REQ,
        RD_WAIT,
        WR_CTRL,
        DONE
    } state_t;

    state_t                               state_r;
    logic [PAT_WIDTH-1:0][REG_WIDTH-1:0]  shadow_r;
    logic                                 enable_r;
    logic [IDX_W-1:0]                     idx_r;
    logic [TMR_W-1:0]                     timer_r;

    logic                                 accept;
    logic                                 last_idx;

    assign accept   = !amm_waitrequest;
    assign last_idx = (idx_r == IDX_W'(PAT_WIDTH - 1));

    // Bus address of pattern word i (pattern words start at address 1).
    function automatic logic [ADDR_WIDTH-1:0] pat_addr(input logic [IDX_W-1:0] i);
        return ADDR_WIDTH'(i) + ADDR_WIDTH'(1);
    endfunction

    // Sequencer: state, shadow registers, timer and all registered bus/status outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r       <= IDLE;
            shadow_r      <= '0;
            enable_r      <= 1'b0;
            idx_r         <= '0;
            timer_r       <= '0;
            amm_address   <= '0;
            amm_write     <= 1'b0;
            amm_writedata <= '0;
            amm_read      <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        shadow_r      <= pattern_i;
                        enable_r      <= enable_i;
                        error_o       <= 1'b0;
                        busy_o        <= 1'b1;
                        idx_r         <= '0;
                        amm_address   <= '0;
                        amm_writedata <= '0;
                        amm_write     <= 1'b1;
                        state_r       <= WR_DIS;
                    end
                end
                WR_DIS: begin
                    if (accept) begin
                        idx_r         <= '0;
                        amm_address   <= pat_addr('0);
                        amm_writedata <= shadow_r[0];
                        state_r       <= WR_PAT;
                    end
                end
                WR_PAT: begin
                    if (accept) begin
                        if (last_idx) begin
                            idx_r       <= '0;
                            amm_write   <= 1'b0;
                            amm_read    <= 1'b1;
                            amm_address <= pat_addr('0);
                            state_r     <= RD_REQ;
                        end else begin
                            idx_r         <= idx_r + IDX_W'(1);
                            amm_address   <= pat_addr(idx_r + IDX_W'(1));
                            amm_writedata <= shadow_r[idx_r + IDX_W'(1)];
                        end
                    end
                end
                RD_REQ: begin
                    if (accept) begin
                        amm_read <= 1'b0;
                        timer_r  <= TMR_W'(RD_TIMEOUT - 1);
                        state_r  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // A valid on the final timer cycle still counts as a response.
                    if (amm_readdatavalid) begin
                        if (amm_readdata != shadow_r[idx_r]) begin
                            error_o <= 1'b1;
                            done_o  <= 1'b1;
                            state_r <= DONE;
                        end else if (last_idx) begin
                            amm_address   <= '0;
                            amm_writedata <= {{(REG_WIDTH-1){1'b0}}, enable_r};
                            amm_write     <= 1'b1;
                            state_r       <= WR_CTRL;
                        end else begin
                            idx_r       <= idx_r + IDX_W'(1);
                            amm_address <= pat_addr(idx_r + IDX_W'(1));
                            amm_read    <= 1'b1;
                            state_r     <= RD_REQ;
                        end
                    end else if (timer_r == '0) begin
                        error_o <= 1'b1;
                        done_o  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        timer_r <= timer_r - TMR_W'(1);
                    end
                end
                WR_CTRL: begin
                    if (accept) begin
                        amm_write <= 1'b0;
                        done_o    <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    amm_read  <= 1'b0;
                    amm_write <= 1'b0;
                    busy_o    <= 1'b0;
                    done_o    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
